aes_enc_iter: RTL and testbench

//  Iterative AES encryption core, parametrised for AES-128/192/256 via KEY_BITS; one round per clock.

---
 rtl/aes_enc_iter_pkg.sv | 67 ++++++
 rtl/aes_enc_iter_if.sv | 23 ++
 rtl/aes_enc_iter_round_comb.sv | 36 +++
 rtl/aes_enc_iter.sv | 183 ++++++++++++++++++
 tb/tb_aes_enc_iter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_enc_iter_pkg.sv
// Shared AES types, S-box and GF(2^8) helpers for the iterative encryption core.
// Used by aes_enc_iter and its round datapath; no configuration macros here.
package aes_enc_iter_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  word_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_DONE
   } fsm_t;

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon_next(input logic [7:0] r);
      return xtime(r);
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   // One MixColumns column; byte a0 is the top row.
   function automatic word_t mixcol_word(input word_t w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// Valid/ready block interface of the iterative AES core: plaintext/key in, ciphertext out.
// The core takes the slave modport; the block-mode wrapper drives the master side.
interface aes_enc_iter_if #(
   parameter int KEY_BITS = 128
);
   logic                in_valid;
   logic                in_ready;
   logic [KEY_BITS-1:0] key_in;
   logic [127:0]        data_in;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        data_out;

   modport master (
      output in_valid, key_in, data_in, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, key_in, data_in, out_ready,
      output in_ready, out_valid, data_out
   );
endinterface

// File: rtl/aes_enc_iter_round_comb.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
// State byte 0 sits in [127:120]; columns are consecutive 32-bit words.
module aes_enc_iter_round_comb
   import aes_enc_iter_pkg::*;
(
   input  state_t state_in,
   input  state_t rk,
   input  logic   last,
   output state_t state_out
);

   state_t sub_s;
   state_t shift_s;
   state_t mix_s;

   // Row r of column c takes the byte from column (c+r) mod 4 of the same row.
   always_comb begin
      sub_s   = '0;
      shift_s = '0;
      mix_s   = '0;
      for (int n = 0; n < 16; n++) begin
         sub_s[127-8*n -: 8] = sbox(state_in[127-8*n -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_s[127-8*(4*c+r) -: 8] = sub_s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_s[127-32*c -: 32] = mixcol_word(shift_s[127-32*c -: 32]);
      end
   end

   assign state_out = (last ? shift_s : mix_s) ^ rk;

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryptor, one round per clock, round keys expanded on the fly.
// Optional macro AES_KEY_REG_EN adds key_load and an internal key register used for every block.
module aes_enc_iter
   import aes_enc_iter_pkg::*;
#(
   parameter int KEY_BITS = 128
)
(
   input logic            clk,
   input logic            rst_n,
`ifdef AES_KEY_REG_EN
   input logic            key_load,
`endif
   aes_enc_iter_if.slave  bus
);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $fatal(1, "aes_enc_iter: KEY_BITS must be 128, 192 or 256");
   end

   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;

   fsm_t                fsm_q, fsm_d;
   state_t              state_q, state_d;
   state_t              data_out_q, data_out_d;
   logic [3:0]          rnd_q, rnd_d;
   logic [KEY_BITS-1:0] win_q, win_d;
   logic [2:0]          phase_q, phase_d;
   logic [7:0]          rcon_q, rcon_d;

   logic [KEY_BITS-1:0] win_next;
   logic [KEY_BITS-1:0] key_sel;
   logic [2:0]          phase_next;
   logic                rcon_used;
   logic                last_round;
   logic                accept_ok;
   logic                in_ready_c;
   logic                out_valid_c;
   state_t              rk_gen;
   state_t              round_out;
   word_t               seq [NK+4];

`ifdef AES_KEY_REG_EN
   logic [KEY_BITS-1:0] key_reg_q, key_reg_d;
   logic                key_ok_q, key_ok_d;

   always_comb begin
      key_reg_d = key_reg_q;
      key_ok_d  = key_ok_q;
      if (fsm_q == ST_IDLE && key_load) begin
         key_reg_d = bus.key_in;
         key_ok_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_reg_q <= '0;
         key_ok_q  <= 1'b0;
      end else begin
         key_reg_q <= key_reg_d;
         key_ok_q  <= key_ok_d;
      end
   end

   // A key_load cycle never doubles as a block accept.
   assign key_sel   = key_reg_q;
   assign accept_ok = key_ok_q && !key_load;
`else
   assign key_sel   = bus.key_in;
   assign accept_ok = 1'b1;
`endif

   // seq holds w[i-NK..i-1] then the four new words w[i..i+3], chained in order.
   // Round r needs w[4r..4r+3], which always lands at seq[4..7]; for NK>4 the
   // upper window words act as the skew buffer that realigns key words.
   always_comb begin
      int    ph;
      word_t t;
      ph        = 0;
      t         = '0;
      seq       = '{default: '0};
      win_next  = '0;
      rcon_used = 1'b0;
      for (int k = 0; k < NK; k++) begin
         seq[k] = win_q[KEY_BITS-1-32*k -: 32];
      end
      for (int k = 0; k < 4; k++) begin
         ph = int'(phase_q) + k;
         if (ph >= NK) ph = ph - NK;
         t = seq[NK+k-1];
         if (ph == 0) begin
            t         = sub_word(rot_word(t)) ^ {rcon_q, 24'h000000};
            rcon_used = 1'b1;
         end else if (NK == 8 && ph == 4) begin
            t = sub_word(t);
         end
         seq[NK+k] = seq[k] ^ t;
      end
      for (int k = 0; k < NK; k++) begin
         win_next[KEY_BITS-1-32*k -: 32] = seq[k+4];
      end
      rk_gen     = {seq[4], seq[5], seq[6], seq[7]};
      phase_next = 3'((int'(phase_q) + 4) % NK);
   end

   assign last_round = (rnd_q == 4'(NR));

   aes_enc_iter_round_comb u_round (
      .state_in  (state_q),
      .rk        (rk_gen),
      .last      (last_round),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      data_out_d  = data_out_q;
      rnd_d       = rnd_q;
      win_d       = win_q;
      phase_d     = phase_q;
      rcon_d      = rcon_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      unique case (fsm_q)
         ST_IDLE: begin
            in_ready_c = accept_ok;
            if (bus.in_valid && accept_ok) begin
               state_d = bus.data_in ^ key_sel[KEY_BITS-1 -: 128];
               win_d   = key_sel;
               rnd_d   = 4'd1;
               phase_d = 3'd0;
               rcon_d  = 8'h01;
               fsm_d   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d = round_out;
            win_d   = win_next;
            phase_d = phase_next;
            rnd_d   = rnd_q + 4'd1;
            if (rcon_used) rcon_d = rcon_next(rcon_q);
            if (last_round) begin
               data_out_d = round_out;
               rnd_d      = 4'd0;
               fsm_d      = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q      <= ST_IDLE;
         state_q    <= '0;
         data_out_q <= '0;
         rnd_q      <= '0;
         win_q      <= '0;
         phase_q    <= '0;
         rcon_q     <= '0;
      end else begin
         fsm_q      <= fsm_d;
         state_q    <= state_d;
         data_out_q <= data_out_d;
         rnd_q      <= rnd_d;
         win_q      <= win_d;
         phase_q    <= phase_d;
         rcon_q     <= rcon_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: one instance per key size sharing stimulus buses.
// Latency is counted with the accept edge as edge 1, so out_valid appears at NR+1.
module tb_aes_enc_iter;

   typedef struct {
      int           sel;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           lat;
   } vec_t;

   vec_t         vt [5];
   logic         clk;
   logic         rst_n;
   logic         valid;
   logic         ordy;
   int           sel;
   logic [255:0] key_bus;
   logic [127:0] pt_bus;
   logic         exp_ir_rst;
   logic         seen;
   int           n_vec = 0;
   int           n_err = 0;
   logic         ir   [3];
   logic         ov   [3];
   logic [127:0] dout [3];
`ifdef AES_KEY_REG_EN
   logic         kload;
`endif

   aes_enc_iter_if #(.KEY_BITS(128)) bus128 ();
   aes_enc_iter_if #(.KEY_BITS(192)) bus192 ();
   aes_enc_iter_if #(.KEY_BITS(256)) bus256 ();

   assign bus128.in_valid  = valid && (sel == 0);
   assign bus192.in_valid  = valid && (sel == 1);
   assign bus256.in_valid  = valid && (sel == 2);
   assign bus128.key_in    = key_bus[255:128];
   assign bus192.key_in    = key_bus[255:64];
   assign bus256.key_in    = key_bus;
   assign bus128.data_in   = pt_bus;
   assign bus192.data_in   = pt_bus;
   assign bus256.data_in   = pt_bus;
   assign bus128.out_ready = ordy;
   assign bus192.out_ready = ordy;
   assign bus256.out_ready = ordy;
   assign ir[0]   = bus128.in_ready;
   assign ir[1]   = bus192.in_ready;
   assign ir[2]   = bus256.in_ready;
   assign ov[0]   = bus128.out_valid;
   assign ov[1]   = bus192.out_valid;
   assign ov[2]   = bus256.out_valid;
   assign dout[0] = bus128.data_out;
   assign dout[1] = bus192.data_out;
   assign dout[2] = bus256.data_out;

   aes_enc_iter #(.KEY_BITS(128)) dut128 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef AES_KEY_REG_EN
      .key_load (kload),
`endif
      .bus      (bus128)
   );

   aes_enc_iter #(.KEY_BITS(192)) dut192 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef AES_KEY_REG_EN
      .key_load (kload),
`endif
      .bus      (bus192)
   );

   aes_enc_iter #(.KEY_BITS(256)) dut256 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef AES_KEY_REG_EN
      .key_load (kload),
`endif
      .bus      (bus256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offers block v until accepted, then scrambles the input buses.
   task automatic accept_block(input int v);
      int guard;
      guard   = 0;
      sel     = vt[v].sel;
      key_bus = vt[v].key;
      pt_bus  = vt[v].pt;
`ifdef AES_KEY_REG_EN
      kload = 1'b1;
      tick();
      kload = 1'b0;
`endif
      valid = 1'b1;
      while (!ir[sel] && guard < 60) begin
         tick();
         guard++;
      end
      check_output("in_ready before accept", 128'(ir[sel]), 128'(1));
      tick();
      valid   = 1'b0;
      key_bus = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      pt_bus  = {$urandom(), $urandom(), $urandom(), $urandom()};
      check_output("in_ready in ROUND", 128'(ir[sel]), 128'(0));
   endtask

   // Called #1 after the accept edge.
   task automatic wait_output(input int s, input int exp_lat, input logic [127:0] exp, input string name);
      int lat;
      lat = 1;
      while (!ov[s] && lat < 60) begin
         tick();
         lat++;
      end
      check_output({name, " latency"}, 128'(lat), 128'(exp_lat));
      check_output({name, " data_out"}, dout[s], exp);
   endtask

   initial begin
      vt[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};
      vt[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 13};
      vt[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 15};
      vt[3] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 11};
      vt[4] = '{0, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 11};

      valid   = 1'b0;
      ordy    = 1'b1;
      sel     = 0;
      key_bus = '0;
      pt_bus  = '0;
      rst_n   = 1'b0;
`ifdef AES_KEY_REG_EN
      kload      = 1'b0;
      exp_ir_rst = 1'b0;
`else
      exp_ir_rst = 1'b1;
`endif

      #12;
      for (int s = 0; s < 3; s++) begin
         check_output($sformatf("reset in_ready[%0d]", s), 128'(ir[s]), 128'(exp_ir_rst));
         check_output($sformatf("reset out_valid[%0d]", s), 128'(ov[s]), 128'(0));
         check_output($sformatf("reset data_out[%0d]", s), dout[s], 128'h0);
      end
      tick();
      rst_n = 1'b1;
      tick();

`ifdef AES_KEY_REG_EN
      valid   = 1'b1;
      sel     = 0;
      key_bus = vt[0].key;
      pt_bus  = vt[0].pt;
      seen    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | ir[0] | ov[0];
      end
      check_output("accept without key", 128'(seen), 128'(0));
      kload = 1'b1;
      check_output("in_ready during key_load", 128'(ir[0]), 128'(0));
      tick();
      kload = 1'b0;
      check_output("in_ready after key_load", 128'(ir[0]), 128'(1));
      key_bus = '0;
      tick();
      valid = 1'b0;
      wait_output(0, 11, vt[0].ct, "stored key 1");
      tick();
      valid = 1'b1;
      tick();
      valid = 1'b0;
      wait_output(0, 11, vt[0].ct, "stored key 2");
      tick();
`endif

      for (int v = 0; v < 5; v++) begin
         accept_block(v);
         wait_output(vt[v].sel, vt[v].lat, vt[v].ct, $sformatf("vec%0d", v));
         tick();
         check_output($sformatf("vec%0d out_valid drop", v), 128'(ov[vt[v].sel]), 128'(0));
         check_output($sformatf("vec%0d back to idle", v), 128'(ir[vt[v].sel]), 128'(1));
      end

      ordy = 1'b0;
      accept_block(0);
      wait_output(0, 11, vt[0].ct, "hold");
      valid   = 1'b1;
      sel     = 0;
      key_bus = vt[0].key;
      pt_bus  = vt[0].pt;
      for (int i = 0; i < 20; i++) begin
         tick();
         check_output("hold data_out", dout[0], vt[0].ct);
         check_output("hold out_valid", 128'(ov[0]), 128'(1));
         check_output("hold in_ready", 128'(ir[0]), 128'(0));
      end
      ordy = 1'b1;
      tick();
      check_output("post handshake out_valid", 128'(ov[0]), 128'(0));
      check_output("post handshake in_ready", 128'(ir[0]), 128'(1));
      tick();
      valid = 1'b0;
      check_output("second block accepted", 128'(ir[0]), 128'(0));
      wait_output(0, 11, vt[0].ct, "second block");
      tick();

      accept_block(0);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #2;
      check_output("mid reset out_valid", 128'(ov[0]), 128'(0));
      check_output("mid reset data_out", dout[0], 128'h0);
      check_output("mid reset in_ready", 128'(ir[0]), 128'(exp_ir_rst));
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         seen = seen | ov[0];
      end
      check_output("partial block emitted", 128'(seen), 128'(0));
      check_output("post reset data_out", dout[0], 128'h0);
      accept_block(0);
      wait_output(0, 11, vt[0].ct, "after reset");
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
